i2c_fifo: RTL
=============

// Module: i2c_fifo
// PURPOSE
//  Synchronous single-clock FIFO between the APB slave interface and the I2C bit engine.
//  Two instances are used: TX (APB writes, I2C engine reads) and RX (I2C engine writes, APB reads).
//  Produces the empty/full/error status consumed by the APB block as TX_EMPTY, RX_EMPTY and ERROR.
// PARAMETERS
//  DWIDTH   32  data word width (matches PWDATA/PRDATA)
//  AWIDTH    5  address width; depth = 2**AWIDTH = 32 entries
// PORTS
//  PCLK      in   1        clock; all state updates on rising edge
//  PRESET    in   1        asynchronous, active-high reset
//  CLEAR     in   1        synchronous flush; pointers and count to 0
//  WR_ENA    in   1        push DATA_IN this cycle
//  RD_ENA    in   1        pop head word this cycle
//  DATA_IN   in   DWIDTH   write data
//  DATA_OUT  out  DWIDTH   registered read data
//  F_FULL    out  1        count == 2**AWIDTH
//  F_EMPTY   out  1        count == 0
//  LEVEL     out  AWIDTH+1 current occupancy, 0..2**AWIDTH
//  ERROR     out  1        one-cycle pulse: overflow or underflow occurred last cycle
// BEHAVIOUR
//  Reset (PRESET=1, async): wr_ptr=rd_ptr=0, LEVEL=0, F_EMPTY=1, F_FULL=0, DATA_OUT=0, ERROR=0.
//   Memory contents are not reset. Reset mid-operation discards all stored words.
//  Pointers: AWIDTH bits, wrap from 2**AWIDTH-1 to 0; LEVEL is a separate AWIDTH+1-bit counter.
//  Flags: F_FULL and F_EMPTY are registered and updated in the same edge as LEVEL.
//  Write accept: wr_ok = WR_ENA & (!F_FULL | rd_ok). Store DATA_IN at wr_ptr, wr_ptr+1.
//  Read accept:  rd_ok = RD_ENA & !F_EMPTY. DATA_OUT <= mem[rd_ptr], rd_ptr+1.
//   Read latency: 1 cycle; DATA_OUT valid the cycle after RD_ENA and holds until the next accepted read.
//  LEVEL: +1 on wr_ok only, -1 on rd_ok only, unchanged when both or neither.
//  Simultaneous WR_ENA & RD_ENA:
//   - empty: write accepted, read rejected (underflow), DATA_OUT unchanged, LEVEL 0->1.
//   - full:  both accepted (read frees slot in same cycle), LEVEL stays 2**AWIDTH.
//   - otherwise both accepted, LEVEL unchanged.
//  Overflow: WR_ENA & !wr_ok. Data dropped, pointers unchanged.
//  Underflow: RD_ENA & !rd_ok. DATA_OUT holds previous value.
//  ERROR <= overflow | underflow; high exactly one cycle per offending cycle.
//  CLEAR: synchronous, overrides WR_ENA/RD_ENA. Next edge: pointers 0, LEVEL 0, F_EMPTY=1, F_FULL=0,
//   ERROR=0. DATA_OUT holds its value.
//  No combinational path from inputs to any output.
// STRUCTURE
//  i2c_pkg: I2C_DWIDTH=32, I2C_FIFO_AWIDTH=5, and the APB register offsets
//   (TX=0, RX=4, CONFIG=8, TIMEOUT=12) shared with the APB slave and bit engine.
//  Sub-module i2c_fifo_ram:
//   - DWIDTH x 2**AWIDTH, 1 write port, 1 registered read port
//   - no reset on storage
//   - infers block or distributed RAM
//  i2c_fifo holds the pointers, LEVEL, flags and ERROR logic.
// TESTING
//  1 Reset then idle: F_EMPTY=1, F_FULL=0, LEVEL=0, DATA_OUT=0, ERROR=0.
//  2 Push 0xA5A5_0001..0xA5A5_0003, then pop 3: DATA_OUT = ...01, ...02, ...03, each 1 cycle after RD_ENA.
//    LEVEL ends at 0 and F_EMPTY=1.
//  3 Fill 32 words: F_FULL=1 and LEVEL=32.
//    33rd push 0xDEAD_BEEF: ERROR pulses 1 cycle, LEVEL stays 32, and the 32 pops return the original data.
//  4 RD_ENA on empty: ERROR pulses, DATA_OUT unchanged.
//    WR_ENA&RD_ENA on empty: LEVEL=1, ERROR=1.
//  5 WR_ENA&RD_ENA at full: no ERROR, LEVEL=32, read returns oldest word.
//    40 mixed cycles check pointer wrap against a scoreboard.
//  6 PRESET asserted asynchronously mid-burst with LEVEL=10: flags and LEVEL reset immediately.
//    CLEAR with LEVEL=5 gives LEVEL=0 on the next edge.

Source files
------------

// File: rtl/i2c_fifo_pkg.sv
// Shared constants for the I2C controller: data/FIFO geometry and APB register offsets.
package i2c_fifo_pkg;

    localparam int unsigned I2C_DWIDTH      = 32;
    localparam int unsigned I2C_FIFO_AWIDTH = 5;
    localparam int unsigned I2C_FIFO_DEPTH  = 1 << I2C_FIFO_AWIDTH;

    typedef enum logic [3:0] {
        APB_TX      = 4'd0,
        APB_RX      = 4'd4,
        APB_CONFIG  = 4'd8,
        APB_TIMEOUT = 4'd12
    } apb_reg_e;

    typedef struct packed {
        logic full;
        logic empty;
        logic error;
    } fifo_status_t;

endpackage

// File: rtl/i2c_fifo_if.sv
// FIFO access bundle: producer/consumer controls towards the FIFO and data/status back.
interface i2c_fifo_if
    import i2c_fifo_pkg::*;
#(
    parameter int unsigned DWIDTH = I2C_DWIDTH,
    parameter int unsigned AWIDTH = I2C_FIFO_AWIDTH
) ();

    logic              CLEAR;
    logic              WR_ENA;
    logic              RD_ENA;
    logic [DWIDTH-1:0] DATA_IN;
    logic [DWIDTH-1:0] DATA_OUT;
    logic              F_FULL;
    logic              F_EMPTY;
    logic [AWIDTH:0]   LEVEL;
    logic              ERROR;

    modport master (
        output CLEAR, WR_ENA, RD_ENA, DATA_IN,
        input  DATA_OUT, F_FULL, F_EMPTY, LEVEL, ERROR
    );

    modport slave (
        input  CLEAR, WR_ENA, RD_ENA, DATA_IN,
        output DATA_OUT, F_FULL, F_EMPTY, LEVEL, ERROR
    );

endinterface

// File: rtl/i2c_fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port; storage is never reset.
module i2c_fifo_ram
    import i2c_fifo_pkg::*;
#(
    parameter int unsigned DWIDTH = I2C_DWIDTH,
    parameter int unsigned AWIDTH = I2C_FIFO_AWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [AWIDTH-1:0] i_wr_addr,
    input  logic [DWIDTH-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [AWIDTH-1:0] i_rd_addr,
    output logic [DWIDTH-1:0] o_rd_data
);

    localparam int unsigned DEPTH = 1 << AWIDTH;

    logic [DWIDTH-1:0] r_mem [DEPTH];
    logic [DWIDTH-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read-before-write on a shared address returns the old word (needed when full).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/i2c_fifo.sv
// Single-clock FIFO between the APB slave and the I2C bit engine; owns pointers, level, flags and error pulse.
module i2c_fifo
    import i2c_fifo_pkg::*;
#(
    parameter int unsigned DWIDTH = I2C_DWIDTH,
    parameter int unsigned AWIDTH = I2C_FIFO_AWIDTH
) (
    input  logic        PCLK,
    input  logic        PRESET,
    i2c_fifo_if.slave   fifo
);

    localparam int unsigned LW    = AWIDTH + 1;
    localparam int unsigned DEPTH = 1 << AWIDTH;

    logic [AWIDTH-1:0] r_wr_ptr;
    logic [AWIDTH-1:0] r_rd_ptr;
    logic [LW-1:0]     r_level;
    logic              r_full;
    logic              r_empty;
    logic              r_error;

    logic              w_rd_ok;
    logic              w_wr_ok;
    logic              w_overflow;
    logic              w_underflow;
    logic [LW-1:0]     w_level_nxt;
    logic [DWIDTH-1:0] w_rd_data;

    // A read on a full FIFO frees the slot the simultaneous write lands in.
    assign w_rd_ok     = fifo.RD_ENA & ~r_empty;
    assign w_wr_ok     = fifo.WR_ENA & (~r_full | w_rd_ok);
    assign w_overflow  = fifo.WR_ENA & ~w_wr_ok;
    assign w_underflow = fifo.RD_ENA & ~w_rd_ok;

    always_comb begin
        w_level_nxt = r_level;
        if (w_wr_ok && !w_rd_ok) begin
            w_level_nxt = r_level + LW'(1);
        end else if (w_rd_ok && !w_wr_ok) begin
            w_level_nxt = r_level - LW'(1);
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_error  <= 1'b0;
        end else if (fifo.CLEAR) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_error  <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + AWIDTH'(1);
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + AWIDTH'(1);
            end
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == LW'(DEPTH));
            r_empty <= (w_level_nxt == '0);
            r_error <= w_overflow | w_underflow;
        end
    end

    i2c_fifo_ram #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) u_ram (
        .clk       (PCLK),
        .rst       (PRESET),
        .i_wr_en   (w_wr_ok & ~fifo.CLEAR),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (fifo.DATA_IN),
        .i_rd_en   (w_rd_ok & ~fifo.CLEAR),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    assign fifo.DATA_OUT = w_rd_data;
    assign fifo.F_FULL   = r_full;
    assign fifo.F_EMPTY  = r_empty;
    assign fifo.LEVEL    = r_level;
    assign fifo.ERROR    = r_error;

endmodule
